// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter for a shared fifo.
// It takes at most one word every two cycles, so the fifo's full flag has settled before each decision.
module fifo_wr_arbiter #(
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [B-1:0] din0,
  input  logic [B-1:0] din1,
  input  logic         full,
  output logic         wr,
  output logic [B-1:0] w_data,
  output logic [1:0]   ack,
  output logic         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           wr_q, wr_d;
  logic [1:0]     ack_q, ack_d;
  logic [B-1:0]   w_data_q, w_data_d;
  logic           last_gnt_q, last_gnt_d;
  logic [1:0]     eligible;
  logic           sel;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    wr_d       = 1'b0;
    ack_d      = 2'b00;
    w_data_d   = w_data_q;
    last_gnt_d = last_gnt_q;
    eligible   = req & {2{~full}};
    sel        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          // On a tie, the requester that was not served last time wins.
          if (eligible == 2'b11) sel = ~last_gnt_q;
          else                   sel = eligible[1];
          state_d    = WRITE;
          wr_d       = 1'b1;
          ack_d      = sel ? 2'b10 : 2'b01;
          w_data_d   = sel ? din1 : din0;
          last_gnt_d = sel;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      ack_q      <= 2'b00;
      w_data_q   <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      ack_q      <= ack_d;
      w_data_q   <= w_data_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign wr     = wr_q;
  assign ack    = ack_q;
  assign w_data = w_data_q;
  assign busy   = (state_q == WRITE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, tie sequence, and random run
// against a cycle model whose accepted words are scoreboarded in grant order.
module tb_fifo_wr_arbiter;

  localparam int B = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [B-1:0] din0, din1;
  logic         full;
  logic         wr;
  logic [B-1:0] w_data;
  logic [1:0]   ack;
  logic         busy;

  fifo_wr_arbiter #(.B(B)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .din0   (din0),
    .din1   (din1),
    .full   (full),
    .wr     (wr),
    .w_data (w_data),
    .ack    (ack),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   ack;
    logic [B-1:0] data;
  } sb_t;

  typedef struct {
    logic         rst;
    logic [1:0]   req;
    logic [B-1:0] d0;
    logic [B-1:0] d1;
    logic         full;
    logic         wr;
    logic [1:0]   ack;
    logic [B-1:0] wdata;
    logic         busy;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  sb_t sb[$];

  // Cycle-level reference model
  logic         m_busy = 1'b0;
  logic         m_last = 1'b1;
  logic [1:0]   m_ack  = 2'b00;
  logic [B-1:0] m_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic [1:0] rq, input logic fl,
                            input logic [B-1:0] d0, input logic [B-1:0] d1);
    logic [1:0] el;
    logic       g;
    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; m_ack = 2'b00; m_wdata = '0;
    end else if (m_busy) begin
      m_busy = 1'b0; m_ack = 2'b00;
    end else begin
      el = fl ? 2'b00 : rq;
      m_ack = 2'b00;
      if (el != 2'b00) begin
        if (el == 2'b01)      g = 1'b0;
        else if (el == 2'b10) g = 1'b1;
        else                  g = (m_last == 1'b0);
        m_busy  = 1'b1;
        m_last  = g;
        m_ack   = g ? 2'b10 : 2'b01;
        m_wdata = g ? d1 : d0;
        sb.push_back('{ack: m_ack, data: m_wdata});
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample just after the edge.
  task automatic run_cycle(input logic rst, input logic [1:0] rq, input logic fl,
                           input logic [B-1:0] d0, input logic [B-1:0] d1);
    sb_t e;
    reset = rst; req = rq; full = fl; din0 = d0; din1 = d1;
    model_step(rst, rq, fl, d0, d1);
    @(posedge clk);
    #1;
    check("model_wr",    {31'd0, wr},   {31'd0, m_busy});
    check("model_ack",   {30'd0, ack},  {30'd0, m_ack});
    check("model_busy",  {31'd0, busy}, {31'd0, m_busy});
    check("model_wdata", {24'd0, w_data}, {24'd0, m_wdata});
    check("invariant",   {29'd0, (ack == 2'b11), (wr != (ack != 2'b00)), (busy != wr)}, 32'd0);
    if (wr) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_ack",  {30'd0, ack},    {30'd0, e.ack});
        check("sb_data", {24'd0, w_data}, {24'd0, e.data});
      end
    end
    check("sb_missing_write", sb.size(), 32'd0);
    sb.delete();
  endtask

  vec_t vecs [0:14];

  initial begin
    logic [1:0]   r_req;
    logic [B-1:0] r_d0, r_d1;
    logic         r_full, r_rst;
    logic [B-1:0] tie_data [0:3];
    logic [1:0]   tie_ack  [0:3];

    reset = 1'b1; req = 2'b00; full = 1'b0; din0 = '0; din1 = '0;

    //            rst  req    d0     d1     full wr  ack    wdata  busy
    vecs[0]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 8'hA5, 8'h00, 1'b0, 1'b1, 2'b01, 8'hA5, 1'b1};
    vecs[2]  = '{1'b0, 2'b01, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 8'h00, 8'h5A, 1'b0, 1'b1, 2'b10, 8'h5A, 1'b1};
    vecs[5]  = '{1'b0, 2'b10, 8'h00, 8'h5A, 1'b1, 1'b0, 2'b00, 8'h5A, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 8'h00, 8'h77, 1'b1, 1'b0, 2'b00, 8'h5A, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 8'h00, 8'h77, 1'b0, 1'b1, 2'b10, 8'h77, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 8'h00, 8'h77, 1'b0, 1'b0, 2'b00, 8'h77, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 8'hC3, 8'h00, 1'b0, 1'b1, 2'b01, 8'hC3, 1'b1};
    vecs[10] = '{1'b1, 2'b01, 8'hC3, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 2'b11, 8'h11, 8'h22, 1'b0, 1'b1, 2'b01, 8'h11, 1'b1};
    vecs[12] = '{1'b0, 2'b11, 8'h11, 8'h22, 1'b0, 1'b0, 2'b00, 8'h11, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 8'h00, 8'h22, 1'b0, 1'b1, 2'b10, 8'h22, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 8'h00, 8'h22, 1'b0, 1'b0, 2'b00, 8'h22, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      run_cycle(vecs[i].rst, vecs[i].req, vecs[i].full, vecs[i].d0, vecs[i].d1);
      check($sformatf("vec%0d_wr", i),    {31'd0, wr},   {31'd0, vecs[i].wr});
      check($sformatf("vec%0d_ack", i),   {30'd0, ack},  {30'd0, vecs[i].ack});
      check($sformatf("vec%0d_wdata", i), {24'd0, w_data}, {24'd0, vecs[i].wdata});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy}, {31'd0, vecs[i].busy});
    end

    // Held full with a pending request, then release.
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, 2'b10, 1'b1, 8'h00, 8'h9C);
      check("full_hold_wr",  {31'd0, wr},  32'd0);
      check("full_hold_ack", {30'd0, ack}, 32'd0);
    end
    run_cycle(1'b0, 2'b10, 1'b0, 8'h00, 8'h9C);
    check("full_release_wr",    {31'd0, wr},     32'd1);
    check("full_release_ack",   {30'd0, ack},    32'd2);
    check("full_release_wdata", {24'd0, w_data}, 32'h9C);
    run_cycle(1'b0, 2'b00, 1'b0, 8'h00, 8'h00);

    // Continuous dual requests alternate after reset: 11,22,11,22.
    tie_data[0] = 8'h11; tie_data[1] = 8'h22; tie_data[2] = 8'h11; tie_data[3] = 8'h22;
    tie_ack[0]  = 2'b01; tie_ack[1]  = 2'b10; tie_ack[2]  = 2'b01; tie_ack[3]  = 2'b10;
    run_cycle(1'b1, 2'b00, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0, 2'b11, 1'b0, 8'h11, 8'h22);
      check("tie_wr", {31'd0, wr}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        check("tie_wdata", {24'd0, w_data}, {24'd0, tie_data[k/2]});
        check("tie_ack",   {30'd0, ack},    {30'd0, tie_ack[k/2]});
      end
    end

    // Random requesters honouring the hold-until-ack contract, with occasional drops and resets.
    r_req = 2'b00; r_d0 = '0; r_d1 = '0; r_full = 1'b0; r_rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      run_cycle(r_rst, r_req, r_full, r_d0, r_d1);
      for (int i = 0; i < 2; i++) begin
        if (r_req[i] && !ack[i] && ($urandom_range(0, 49) != 0)) begin
          r_req[i] = 1'b1;
        end else begin
          r_req[i] = ($urandom_range(0, 2) != 0);
          if (i == 0) r_d0 = B'($urandom);
          else        r_d1 = B'($urandom);
        end
      end
      r_full = ($urandom_range(0, 2) == 0);
      r_rst  = ($urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
